// File: rtl/pipeline_stage_regs_ctrl.sv
// Control fields of the ID/EX, EX/MEM and MEM/WB pipeline registers. Also
// generates the PC and IF/ID enables from stall/flush, counts stall cycles
// and raises a sticky error when a stall lasts too long.
module pipeline_stage_regs_ctrl #(
    parameter int STALL_TIMEOUT = 15,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             id_we,
    input  logic             id_sw1,
    input  logic [2:0]       id_ra,
    input  logic [2:0]       id_rb,
    input  logic             id_sm2,
    input  logic             id_sw2,
    output logic             ex_valid,
    output logic [2:0]       ra_ex,
    output logic [2:0]       rb_ex,
    output logic             ex_we,
    output logic             ex_sw1,
    output logic             ex_sm2,
    output logic             ex_sw2,
    output logic             we_mem,
    output logic             sw1_mem,
    output logic             sm2_mem,
    output logic             sw2_mem,
    output logic [2:0]       ra_mem,
    output logic [2:0]       rb_mem,
    output logic             we_wb,
    output logic             sw1_wb,
    output logic             sw2_wb,
    output logic [2:0]       ra_wb,
    output logic [2:0]       rb_wb,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             timeout_err
);

    localparam logic [7:0] TIMEOUT = 8'(STALL_TIMEOUT);

    typedef enum logic [1:0] {RUN, STALLED, ERR} state_t;

    state_t     state, state_nxt;
    logic [7:0] run_len, run_len_nxt;

    // A stall freezes fetch; a flush only clears IF/ID when fetch is moving,
    // since a stalled branch cannot have resolved yet.
    assign pc_we      = ~stall;
    assign ifid_we    = ~stall;
    assign ifid_flush = flush & ~stall;

    // ID/EX: hold on stall, bubble on flush, otherwise load from ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_we    <= 1'b0;
            ex_sw1   <= 1'b0;
            ex_sm2   <= 1'b0;
            ex_sw2   <= 1'b0;
            ra_ex    <= '0;
            rb_ex    <= '0;
        end else if (!stall) begin
            ra_ex  <= id_ra;
            rb_ex  <= id_rb;
            ex_sw1 <= id_sw1;
            if (flush) begin
                ex_valid <= 1'b0;
                ex_we    <= 1'b0;
                ex_sm2   <= 1'b0;
                ex_sw2   <= 1'b0;
            end else begin
                ex_valid <= id_valid;
                ex_we    <= id_we & id_valid;
                ex_sm2   <= id_sm2;
                ex_sw2   <= id_sw2;
            end
        end
    end

    // EX/MEM: a stalled or empty EX slot becomes a bubble in MEM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_mem  <= 1'b0;
            sw1_mem <= 1'b0;
            sm2_mem <= 1'b0;
            sw2_mem <= 1'b0;
            ra_mem  <= '0;
            rb_mem  <= '0;
        end else begin
            sw1_mem <= ex_sw1;
            ra_mem  <= ra_ex;
            rb_mem  <= rb_ex;
            if (stall || !ex_valid) begin
                we_mem  <= 1'b0;
                sm2_mem <= 1'b0;
                sw2_mem <= 1'b0;
            end else begin
                we_mem  <= ex_we;
                sm2_mem <= ex_sm2;
                sw2_mem <= ex_sw2;
            end
        end
    end

    // MEM/WB: unconditional copy; load select is consumed in MEM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_wb  <= 1'b0;
            sw1_wb <= 1'b0;
            sw2_wb <= 1'b0;
            ra_wb  <= '0;
            rb_wb  <= '0;
        end else begin
            we_wb  <= we_mem;
            sw1_wb <= sw1_mem;
            sw2_wb <= sw2_mem;
            ra_wb  <= ra_mem;
            rb_wb  <= rb_mem;
        end
    end

    // Total stall cycles, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    // Stall-watchdog state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            run_len <= '0;
        end else begin
            state   <= state_nxt;
            run_len <= run_len_nxt;
        end
    end

    // Stall-watchdog next state; run_len counts the current stall run
    always_comb begin
        state_nxt   = state;
        run_len_nxt = run_len;
        case (state)
            RUN: begin
                if (stall) begin
                    run_len_nxt = 8'd1;
                    state_nxt   = (TIMEOUT == 8'd1) ? ERR : STALLED;
                end
            end
            STALLED: begin
                if (stall) begin
                    run_len_nxt = run_len + 8'd1;
                    if (run_len_nxt == TIMEOUT)
                        state_nxt = ERR;
                end else begin
                    run_len_nxt = '0;
                    state_nxt   = RUN;
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = RUN;
        endcase
    end

    // Stall-watchdog outputs: ERR is terminal until reset
    always_comb begin
        timeout_err = (state == ERR);
    end

endmodule

// File: tb/tb_pipeline_stage_regs_ctrl.sv
// Directed bench for pipeline_stage_regs_ctrl: default instance plus a
// CNT_W=4 / STALL_TIMEOUT=255 instance sharing the same stimulus.
module tb_pipeline_stage_regs_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic stall, flush, id_valid, id_we, id_sw1, id_sm2, id_sw2;
    logic [2:0] id_ra, id_rb;

    logic ex_valid, ex_we, ex_sw1, ex_sm2, ex_sw2;
    logic [2:0] ra_ex, rb_ex, ra_mem, rb_mem, ra_wb, rb_wb;
    logic we_mem, sw1_mem, sm2_mem, sw2_mem, we_wb, sw1_wb, sw2_wb;
    logic pc_we, ifid_we, ifid_flush, timeout_err;
    logic [15:0] stall_cnt;

    logic s_ex_valid, s_ex_we, s_ex_sw1, s_ex_sm2, s_ex_sw2;
    logic [2:0] s_ra_ex, s_rb_ex, s_ra_mem, s_rb_mem, s_ra_wb, s_rb_wb;
    logic s_we_mem, s_sw1_mem, s_sm2_mem, s_sw2_mem, s_we_wb, s_sw1_wb, s_sw2_wb;
    logic s_pc_we, s_ifid_we, s_ifid_flush, s_timeout_err;
    logic [3:0] s_stall_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipeline_stage_regs_ctrl dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_we(id_we), .id_sw1(id_sw1), .id_ra(id_ra),
        .id_rb(id_rb), .id_sm2(id_sm2), .id_sw2(id_sw2),
        .ex_valid(ex_valid), .ra_ex(ra_ex), .rb_ex(rb_ex), .ex_we(ex_we),
        .ex_sw1(ex_sw1), .ex_sm2(ex_sm2), .ex_sw2(ex_sw2),
        .we_mem(we_mem), .sw1_mem(sw1_mem), .sm2_mem(sm2_mem), .sw2_mem(sw2_mem),
        .ra_mem(ra_mem), .rb_mem(rb_mem), .we_wb(we_wb), .sw1_wb(sw1_wb),
        .sw2_wb(sw2_wb), .ra_wb(ra_wb), .rb_wb(rb_wb), .pc_we(pc_we),
        .ifid_we(ifid_we), .ifid_flush(ifid_flush), .stall_cnt(stall_cnt),
        .timeout_err(timeout_err)
    );

    pipeline_stage_regs_ctrl #(.STALL_TIMEOUT(255), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_we(id_we), .id_sw1(id_sw1), .id_ra(id_ra),
        .id_rb(id_rb), .id_sm2(id_sm2), .id_sw2(id_sw2),
        .ex_valid(s_ex_valid), .ra_ex(s_ra_ex), .rb_ex(s_rb_ex), .ex_we(s_ex_we),
        .ex_sw1(s_ex_sw1), .ex_sm2(s_ex_sm2), .ex_sw2(s_ex_sw2),
        .we_mem(s_we_mem), .sw1_mem(s_sw1_mem), .sm2_mem(s_sm2_mem), .sw2_mem(s_sw2_mem),
        .ra_mem(s_ra_mem), .rb_mem(s_rb_mem), .we_wb(s_we_wb), .sw1_wb(s_sw1_wb),
        .sw2_wb(s_sw2_wb), .ra_wb(s_ra_wb), .rb_wb(s_rb_wb), .pc_we(s_pc_we),
        .ifid_we(s_ifid_we), .ifid_flush(s_ifid_flush), .stall_cnt(s_stall_cnt),
        .timeout_err(s_timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock, then sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic v, input logic we, input logic sw1,
                          input logic [2:0] ra, input logic [2:0] rb,
                          input logic sm2, input logic sw2);
        id_valid = v; id_we = we; id_sw1 = sw1; id_ra = ra; id_rb = rb;
        id_sm2 = sm2; id_sw2 = sw2;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        id_set(0, 0, 0, 3'd0, 3'd0, 0, 0);
        #2;
        // power-on reset state
        chk("por_ex_valid", ex_valid, 0);
        chk("por_we_wb", we_wb, 0);
        chk("por_stall_cnt", stall_cnt, 0);
        chk("por_timeout", timeout_err, 0);
        chk("por_pc_we", pc_we, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // reset mid-stream: three loads plus one stall, then async pulse
        id_set(1, 1, 0, 3'd1, 3'd0, 0, 0);
        tick();
        id_ra = 3'd2;
        tick();
        id_ra = 3'd3;
        tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        chk("mid_ra_ex", ra_ex, 3);
        chk("mid_we_wb", we_wb, 1);
        chk("mid_ra_wb", ra_wb, 2);
        chk("mid_stall_cnt", stall_cnt, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ra_ex", ra_ex, 0);
        chk("rst_ex_we", ex_we, 0);
        chk("rst_we_mem", we_mem, 0);
        chk("rst_ra_mem", ra_mem, 0);
        chk("rst_we_wb", we_wb, 0);
        chk("rst_ra_wb", ra_wb, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_pc_we", pc_we, 1);
        id_set(0, 0, 0, 3'd0, 3'd0, 0, 0);
        #1;
        rst_n = 1'b1;

        // load-use: load r1, then add using r1, stall while add sits in EX
        id_set(1, 1, 0, 3'd1, 3'd0, 1, 0);
        tick();
        id_set(1, 1, 1, 3'd1, 3'd2, 0, 0);
        tick();
        chk("lu_sm2_mem", sm2_mem, 1);
        chk("lu_ra_mem", ra_mem, 1);
        chk("lu_ra_ex", ra_ex, 1);
        stall = 1'b1;
        #1;
        chk("lu_pc_we", pc_we, 0);
        chk("lu_ifid_we", ifid_we, 0);
        tick();
        stall = 1'b0;
        chk("lu_hold_ra_ex", ra_ex, 1);
        chk("lu_hold_rb_ex", rb_ex, 2);
        chk("lu_bubble_we_mem", we_mem, 0);
        chk("lu_bubble_sm2_mem", sm2_mem, 0);
        chk("lu_we_wb", we_wb, 1);
        chk("lu_ra_wb", ra_wb, 1);
        chk("lu_sw1_wb", sw1_wb, 0);
        chk("lu_stall_cnt", stall_cnt, 1);
        tick();
        chk("lu_add_we_mem", we_mem, 1);
        chk("lu_add_rb_mem", rb_mem, 2);
        chk("lu_add_sw1_mem", sw1_mem, 1);
        chk("lu_bubble_we_wb", we_wb, 0);

        // flush: ID content is squashed into an EX bubble
        id_set(1, 1, 0, 3'd4, 3'd4, 1, 1);
        flush = 1'b1;
        #1;
        chk("fl_ifid_flush", ifid_flush, 1);
        chk("fl_pc_we", pc_we, 1);
        tick();
        flush = 1'b0;
        chk("fl_ex_valid", ex_valid, 0);
        chk("fl_ex_we", ex_we, 0);
        chk("fl_ex_sm2", ex_sm2, 0);
        chk("fl_ex_sw2", ex_sw2, 0);
        chk("fl_branch_we_mem", we_mem, 1);
        id_set(1, 1, 0, 3'd5, 3'd6, 0, 1);
        tick();
        chk("fl_bubble_we_mem", we_mem, 0);
        chk("fl_load_ex_valid", ex_valid, 1);
        chk("fl_load_ra_ex", ra_ex, 5);
        chk("fl_load_ex_sw2", ex_sw2, 1);

        // stall and flush together: stall wins
        id_set(1, 0, 1, 3'd7, 3'd7, 1, 0);
        stall = 1'b1;
        flush = 1'b1;
        #1;
        chk("sf_ifid_flush", ifid_flush, 0);
        chk("sf_pc_we", pc_we, 0);
        tick();
        stall = 1'b0;
        flush = 1'b0;
        chk("sf_ex_valid", ex_valid, 1);
        chk("sf_ra_ex", ra_ex, 5);
        chk("sf_ex_we", ex_we, 1);
        chk("sf_ex_sw2", ex_sw2, 1);
        chk("sf_we_mem", we_mem, 0);
        chk("sf_sw2_mem", sw2_mem, 0);
        chk("sf_stall_cnt", stall_cnt, 2);
        tick();

        // timeout: 15 consecutive stall cycles
        stall = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("to_before", timeout_err, 0);
        tick();
        chk("to_after", timeout_err, 1);
        chk("to_stall_cnt", stall_cnt, 17);
        chk("to_sat_inst_err", s_timeout_err, 0);
        stall = 1'b0;
        id_set(1, 1, 0, 3'd3, 3'd1, 0, 0);
        #1;
        chk("to_pc_we", pc_we, 1);
        tick();
        chk("to_sticky", timeout_err, 1);
        chk("to_resume_ra_ex", ra_ex, 3);
        chk("to_resume_valid", ex_valid, 1);

        // saturation on the 4-bit counter instance
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("sat_rst_cnt", s_stall_cnt, 0);
        stall = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", s_stall_cnt, 14);
        tick();
        chk("sat_15", s_stall_cnt, 15);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_20", s_stall_cnt, 15);
        chk("sat_timeout", s_timeout_err, 0);
        chk("sat_wide_cnt", stall_cnt, 20);
        chk("sat_wide_timeout", timeout_err, 1);
        stall = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_regs_ctrl.md
Name: pipeline_stage_regs_ctrl

Overview:
- Owns the hazard-relevant control fields of the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Feeds the hazard/forwarding unit the fields it compares: ra_ex/rb_ex, *_mem and *_wb.
- Consumes that unit's stall output, plus the EX-stage branch flush, to generate PC/IF-ID enables and bubble insertion.
- Tracks stall statistics and flags a stuck pipeline.

Parameters:
STALL_TIMEOUT, 15, consecutive stall cycles that raise timeout_err (range 1..255)
CNT_W, 16, width of the saturating total-stall counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  load-use stall from the hazard/forwarding unit
flush  in  1  taken branch/jump resolved in EX; squash younger instructions
id_valid  in  1  ID stage holds a real instruction
id_we  in  1  ID instruction writes the register file
id_sw1  in  1  ID dest select (0=Ra, 1=Rb)
id_ra  in  3  ID source/dest A address
id_rb  in  3  ID source/dest B address
id_sm2  in  1  ID instruction is a memory load
id_sw2  in  1  ID write data comes from the input port
ex_valid  out  1  EX stage valid
ra_ex  out  3  EX Ra address
rb_ex  out  3  EX Rb address
ex_we, ex_sw1, ex_sm2, ex_sw2  out  1 each  EX control fields
we_mem, sw1_mem, sm2_mem, sw2_mem  out  1 each  MEM control fields
ra_mem, rb_mem  out  3 each  MEM addresses
we_wb, sw1_wb, sw2_wb  out  1 each  WB control fields
ra_wb, rb_wb  out  3 each  WB addresses
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID register enable
ifid_flush  out  1  clear IF/ID to NOP
stall_cnt  out  CNT_W  total stall cycles, saturating
timeout_err  out  1  sticky: stall held STALL_TIMEOUT consecutive cycles

Behaviour:
Reset (async, rst_n=0):
- All registered outputs go to 0: valids, we, sw*, sm2, addresses, stall_cnt, timeout_err, and the FSM (RUN).
- A mid-operation reset discards all in-flight state immediately.

Combinational outputs:
- pc_we = ifid_we = ~stall.
- ifid_flush = flush & ~stall.

ID/EX, evaluated in priority order each clock:
- stall=1: hold all EX fields. flush is ignored, because a stalled branch cannot have resolved.
- Else flush=1: bubble. ex_valid=0, ex_we=0, ex_sm2=0, ex_sw2=0. Addresses load from ID (don't-care).
- Else load: ex_valid<=id_valid, ex_we<=id_we&id_valid, remaining fields copied from ID.

EX/MEM:
- stall=1 or ex_valid=0: bubble. we_mem=0, sm2_mem=0, sw2_mem=0; sw1/addresses copy from EX.
- Otherwise copy the EX fields.
- The branch in EX during flush proceeds normally.

MEM/WB:
- Always copies from EX/MEM. Never stalls. sm2 is not propagated.

Latency and pipeline contract:
- Each field moves one stage per unstalled cycle.
- A one-cycle stall delays EX by exactly one cycle and inserts one bubble in MEM.
- The next cycle the load sits in WB, so the hazard unit's WB forwarding resolves the dependency.

Stall FSM (states RUN, STALLED, ERR) with an 8-bit run_len:
- RUN: on stall=1 go to STALLED, run_len<=1.
- STALLED:
  - stall=1: run_len++.
  - If run_len+1 == STALL_TIMEOUT: go to ERR and set timeout_err.
  - stall=0: go to RUN, run_len<=0.
- ERR: timeout_err stays 1 until reset. Pipeline control keeps following stall normally.
- STALL_TIMEOUT=1: the first stall cycle enters ERR directly.

stall_cnt:
- Increments on every clock with stall=1.
- Saturates at 2^CNT_W-1; no wrap.

Test Plan:
- Reset mid-stream: load 3 valid instructions, pulse rst_n low for 1 cycle between clock edges -> every registered output reads 0 immediately, stall_cnt=0, pc_we=1.
- Load-use:
  - Stimulus: ID load (id_we=1, id_sw1=0, id_ra=1, id_sm2=1), then ID add (id_ra=1); stall=1 for the one cycle the add is in EX.
  - Response: that cycle pc_we=ifid_we=0. Next cycle ra_ex=1 (held), we_mem=0 (bubble), we_wb=1 with ra_wb=1. stall_cnt=1.
- Flush: flush=1, stall=0, id_valid=1, id_we=1 -> ifid_flush=1, pc_we=1; next cycle ex_valid=0, ex_we=0. Following cycle we_mem=0.
- Simultaneous stall=1 and flush=1 -> ifid_flush=0, pc_we=0, EX fields unchanged, we_mem=0.
- Timeout: stall held 15 cycles (default) -> timeout_err rises after edge 15; stall drops -> timeout_err stays 1 and the pipeline resumes loading.
- Saturation with CNT_W=4, STALL_TIMEOUT=255: 20 stall cycles -> stall_cnt=15, timeout_err=0.
